// File: rtl/lcd_frame_scheduler.sv
// Frame pacer for the four-panel LCD driver: start strobe, busy/halt tracking, and front/back bank select.
// Optional build macro LCD_SCHED_STATS_EN adds the frame_cnt_o / skip_cnt_o counters (tied to 0 otherwise).
module lcd_frame_scheduler #(
  parameter int unsigned FRAME_TICKS = 2000000,
  parameter int unsigned START_PULSE = 4,
  parameter int unsigned TIMEOUT     = 65535,
  parameter logic [2:0]  HALT_CODE   = 3'd7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable_i,
  input  logic [2:0]  drv_state_i,
  output logic        drv_start_o,
  input  logic        swap_req_i,
  output logic        swap_ack_o,
  output logic        front_sel_o,
  output logic        back_sel_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic [15:0] frame_cnt_o,
  output logic [7:0]  skip_cnt_o
);

  // state     | meaning
  // S_IDLE    | waiting for the frame tick; only place a buffer swap is taken
  // S_PULSE   | drv_start_o held high for START_PULSE cycles
  // S_WAIT_BUSY | start released, waiting for the driver to leave HALT
  // S_WAIT_DONE | driver running, waiting for it to return to HALT
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PULSE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned PW = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(START_PULSE - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tick_cnt;
  logic [PW-1:0]   r_pulse_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_front_sel;
  logic            r_swap_ack;
  logic            r_guard;
  logic            r_timeout;
  logic            w_tick;
  logic            w_swap;
  logic            w_guard;
  logic            w_waiting;
  logic            w_timeout_hit;

  // Down-counter equivalent of a 0..FRAME_TICKS-1 up-count; tick at terminal count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tick_cnt <= TICK_LAST;
    end else if (!enable_i || r_tick_cnt == '0) begin
      r_tick_cnt <= TICK_LAST;
    end else begin
      r_tick_cnt <= r_tick_cnt - TW'(1);
    end
  end

  assign w_tick    = enable_i && (r_tick_cnt == '0);
  assign w_guard   = r_swap_ack | r_guard;
  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

  always_comb begin
    w_state_nxt   = r_state;
    w_swap        = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_swap      = swap_req_i && !w_guard;
          w_state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_pulse_cnt == '0) begin
          w_state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (drv_state_i != HALT_CODE) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_wait_cnt == '0) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (drv_state_i == HALT_CODE) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == '0) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pulse_cnt <= PULSE_LAST;
    end else if (r_state != S_PULSE) begin
      r_pulse_cnt <= PULSE_LAST;
    end else if (r_pulse_cnt != '0) begin
      r_pulse_cnt <= r_pulse_cnt - PW'(1);
    end
  end

  // Reloaded on every state change so each wait state gets a full TIMEOUT budget.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait_cnt <= WAIT_LAST;
    end else if (w_state_nxt != r_state) begin
      r_wait_cnt <= WAIT_LAST;
    end else if (w_waiting && r_wait_cnt != '0) begin
      r_wait_cnt <= r_wait_cnt - WW'(1);
    end
  end

  // Guard spans the ack cycle and the one after it, covering requester deassertion latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_front_sel <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_guard     <= 1'b0;
    end else begin
      r_swap_ack <= w_swap;
      r_guard    <= r_swap_ack;
      if (w_swap) begin
        r_front_sel <= ~r_front_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      r_timeout <= 1'b1;
    end
  end

`ifdef LCD_SCHED_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_skip_cnt;
  logic        w_frame_done;
  logic        w_skip;

  assign w_frame_done = (r_state == S_WAIT_DONE) && (drv_state_i == HALT_CODE);
  assign w_skip       = w_tick && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= 16'd0;
      r_skip_cnt  <= 8'd0;
    end else begin
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_skip && r_skip_cnt != 8'hFF) begin
        r_skip_cnt <= r_skip_cnt + 8'd1;
      end
    end
  end

  assign frame_cnt_o = r_frame_cnt;
  assign skip_cnt_o  = r_skip_cnt;
`else
  assign frame_cnt_o = 16'd0;
  assign skip_cnt_o  = 8'd0;
`endif

  assign drv_start_o = (r_state == S_PULSE);
  assign busy_o      = (r_state != S_IDLE);
  assign swap_ack_o  = r_swap_ack;
  assign front_sel_o = r_front_sel;
  assign back_sel_o  = ~r_front_sel;
  assign timeout_o   = r_timeout;

endmodule
